// File: rtl/matmul_pkg.sv
// Shared constants, control-state encoding and result byte selection for the UART 2x2
// matrix multiplier.
package matmul_pkg;

    localparam int unsigned N                    = 2;
    localparam int unsigned DATA_W               = 8;
    localparam int unsigned RES_W                = 24;
    localparam int unsigned IN_BYTES             = 8;
    localparam int unsigned OUT_BYTES            = 12;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        StRxA,
        StRxB,
        StCompute,
        StTx
    } state_e;

    // Big-endian byte slice of a result word: part 0 is bits 23:16.
    function automatic logic [DATA_W-1:0] get_byte(input logic [RES_W-1:0] v,
                                                   input logic [1:0]       part);
        case (part)
            2'd0:    return v[23:16];
            2'd1:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_phy.sv
// 8N1 UART byte engines: synchronised receiver with glitch and framing rejection, and a
// transmitter that accepts a new byte in the last stop-bit cycle for gapless streaming.
module uart_phy
    import matmul_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    input  logic              tx_start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_st_q, rx_st_d;
    logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic              tx_busy_q, tx_busy_d;
    logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_idx_q, tx_idx_d;
    logic [9:0]        tx_frame_q, tx_frame_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_ready;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (rx_st_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_st_d = RxStart;
            end
            RxStart: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (rx_cnt_q == HalfBit) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_st_d  = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_st_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_st_d = RxIdle;
                    if (rx_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    always_comb begin
        tx_ready   = !tx_busy_q ||
                     (tx_cnt_q == BitLast && tx_idx_q == 4'd9);
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_frame_d = tx_frame_q;
        if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_cnt_q == BitLast) begin
                tx_cnt_d   = '0;
                tx_frame_d = {1'b1, tx_frame_q[9:1]};
                tx_idx_d   = tx_idx_q + 4'd1;
                if (tx_idx_q == 4'd9) tx_busy_d = 1'b0;
            end
        end
        if (tx_start_i && tx_ready) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_idx_d   = '0;
            tx_frame_d = {1'b1, tx_data_i, 1'b0};
        end
        tx_out_d = tx_busy_d ? tx_frame_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_frame_q <= '1;
            tx_out_q   <= 1'b1;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_frame_q <= tx_frame_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign tx_busy_o  = !tx_ready;
    assign tx_o       = tx_out_q;

endmodule

// File: rtl/top_arty_matrix_mult.sv
// Arty top level: receives A and B over UART, computes C = A x B one element per clock,
// then streams the four 24-bit results back big-endian.
module top_arty_matrix_mult
    import matmul_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx
);

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    state_e                          state_q, state_d;
    logic [2:0]                      in_cnt_q, in_cnt_d;
    logic [3:0]                      out_cnt_q, out_cnt_d;
    logic [N*N-1:0][DATA_W-1:0]      a_q, a_d, b_q, b_d;
    logic [N*N-1:0][RES_W-1:0]       c_q, c_d;

    logic [1:0]          ci;
    logic [2*DATA_W-1:0] p0, p1;
    logic [2*DATA_W:0]   mac;

    uart_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (uart_rx),
        .tx_o      (uart_tx),
        .rx_valid_o(rx_valid),
        .rx_data_o (rx_data),
        .tx_start_i(tx_start),
        .tx_data_i (tx_data),
        .tx_busy_o (tx_busy)
    );

    // During COMPUTE the low counter bits select element Cij as {i, j}.
    always_comb begin
        ci  = in_cnt_q[1:0];
        p0  = {{DATA_W{1'b0}}, a_q[{ci[1], 1'b0}]} * {{DATA_W{1'b0}}, b_q[{1'b0, ci[0]}]};
        p1  = {{DATA_W{1'b0}}, a_q[{ci[1], 1'b1}]} * {{DATA_W{1'b0}}, b_q[{1'b1, ci[0]}]};
        mac = {1'b0, p0} + {1'b0, p1};
    end

    assign tx_data = get_byte(c_q[2'(out_cnt_q / 4'd3)], 2'(out_cnt_q % 4'd3));

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        tx_start  = 1'b0;
        unique case (state_q)
            StRxA: begin
                if (rx_valid) begin
                    a_d[in_cnt_q[1:0]] = rx_data;
                    in_cnt_d           = in_cnt_q + 3'd1;
                    if (in_cnt_q[1:0] == 2'd3) state_d = StRxB;
                end
            end
            StRxB: begin
                if (rx_valid) begin
                    b_d[in_cnt_q[1:0]] = rx_data;
                    in_cnt_d           = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'(IN_BYTES - 1)) begin
                        state_d  = StCompute;
                        in_cnt_d = '0;
                    end
                end
            end
            StCompute: begin
                c_d[ci]  = {{(RES_W - 2*DATA_W - 1){1'b0}}, mac};
                in_cnt_d = in_cnt_q + 3'd1;
                if (ci == 2'd3) begin
                    state_d   = StTx;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            StTx: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'(OUT_BYTES - 1)) begin
                        state_d   = StRxA;
                        out_cnt_d = '0;
                    end
                end
            end
            default: state_d = StRxA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRxA;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
        end
    end

endmodule

// File: tb/tb_top_arty_matrix_mult.sv
// Directed bench for the UART matrix multiplier, run at a reduced bit period to keep
// transactions short.
module tb_top_arty_matrix_mult;

    localparam int unsigned CLK_FREQ_HZ = 1_600_000;
    localparam int unsigned BAUD        = 100_000;
    localparam int          CPB         = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int rst_gen  = 0;
    int stop_cyc = 0;
    int mon_err  = 0;
    logic [7:0] mon_q[$];
    int         fall_q[$];

    top_arty_matrix_mult #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_gen <= rst_gen + 1;

    // Byte decoder on uart_tx; a byte cut short by reset is dropped.
    initial begin : monitor
        logic [7:0] sh;
        logic       st;
        logic       sp;
        int         g;
        int         fc;
        forever begin
            @(negedge uart_tx);
            @(negedge clk);
            g  = rst_gen;
            fc = cyc;
            repeat (CPB / 2 - 1) @(negedge clk);
            st = uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                sh[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            sp = uart_tx;
            if (g == rst_gen && rst_n) begin
                if (st !== 1'b0 || sp !== 1'b1) mon_err++;
                mon_q.push_back(sh);
                fall_q.push_back(fc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        stop_cyc = cyc;
        uart_rx  = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_txn(input logic [7:0] v [8]);
        for (int i = 0; i < 8; i++) send_byte(v[i], 1'b1);
    endtask

    task automatic collect(input int n, output logic [7:0] r [12], output int got);
        for (int i = 0; i < 20000 && mon_q.size() < n; i++) @(negedge clk);
        got = mon_q.size();
        for (int i = 0; i < 12; i++) r[i] = (i < n && mon_q.size() > 0) ? mon_q.pop_front() : 'x;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL reset_tx got=%b want=1", uart_tx);
        end
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL idle_tx got=%b want=1", uart_tx);
        end
        total++;
        if (mon_q.size() != 0) begin
            bad++; $display("FAIL idle_bytes got=%0d want=0", mon_q.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] v [8];
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        int f [12];
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
              8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
        mon_q.delete();
        fall_q.delete();
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) f[i] = (i < fall_q.size()) ? fall_q[i] : 0;
        total++;
        if (n != 12) begin
            bad++; $display("FAIL basic_count got=%0d want=12", n);
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
        total++;
        if (f[0] - stop_cyc < CPB / 2 || f[0] - stop_cyc > CPB / 2 + 12) begin
            bad++; $display("FAIL basic_latency got=%0d want=%0d..%0d", f[0] - stop_cyc,
                            CPB / 2, CPB / 2 + 12);
        end
        for (int i = 1; i < 12; i++) begin
            total++;
            if (f[i] - f[i-1] != 10 * CPB) begin
                bad++; $display("FAIL basic_spacing%0d got=%0d want=%0d", i, f[i] - f[i-1],
                                10 * CPB);
            end
        end
        repeat (CPB) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL basic_idle_after got=%b want=1", uart_tx);
        end
    endtask

    task automatic test_max_and_identity();
        logic [7:0] v [8];
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        e = '{8'h01, 8'hFC, 8'h02, 8'h01, 8'hFC, 8'h02,
              8'h01, 8'hFC, 8'h02, 8'h01, 8'hFC, 8'h02};
        mon_q.delete();
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL max_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
        v = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h09, 8'h08, 8'h07, 8'h06};
        e = '{8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h08,
              8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h06};
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL ident_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
    endtask

    task automatic test_framing();
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        e = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h0A,
              8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h1A};
        mon_q.delete();
        send_byte(8'h02, 1'b1);
        send_byte(8'h77, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h07, 1'b1);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL frame_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] v [8];
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        v = '{8'h03, 8'h01, 8'h02, 8'h04, 8'h05, 8'h00, 8'h01, 8'h02};
        e = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
              8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h08};
        mon_q.delete();
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        total++;
        if (mon_q.size() != 0) begin
            bad++; $display("FAIL glitch_bytes got=%0d want=0", mon_q.size());
        end
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL glitch_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v [8];
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
              8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
        mon_q.delete();
        for (int i = 0; i < 5; i++) send_byte(v[i], 1'b1);
        rst_n = 1'b0;
        #1;
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL rstrx_tx got=%b want=1", uart_tx);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (40 * CPB) @(negedge clk);
        total++;
        if (mon_q.size() != 0) begin
            bad++; $display("FAIL rstrx_bytes got=%0d want=0", mon_q.size());
        end
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL rstrx_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
        v = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h09, 8'h08, 8'h07, 8'h06};
        send_txn(v);
        collect(5, r, n);
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL rsttx_tx got=%b want=1", uart_tx);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (40 * CPB) @(negedge clk);
        total++;
        if (mon_q.size() != 0 || uart_tx !== 1'b1) begin
            bad++; $display("FAIL rsttx_quiet got=%0d bytes tx=%b want=0 bytes tx=1",
                            mon_q.size(), uart_tx);
        end
        v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        e = '{8'h01, 8'hFC, 8'h02, 8'h01, 8'hFC, 8'h02,
              8'h01, 8'hFC, 8'h02, 8'h01, 8'hFC, 8'h02};
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL rsttx_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [8];
        logic [7:0] e [12];
        logic [7:0] r [12];
        int n;
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
              8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
        mon_q.delete();
        send_txn(v);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL b2b1_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
        v = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h09, 8'h08, 8'h07, 8'h06};
        e = '{8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h08,
              8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h06};
        send_txn(v);
        collect(12, r, n);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (r[i] !== e[i]) begin
                bad++; $display("FAIL b2b2_byte%0d got=%h want=%h", i, r[i], e[i]);
            end
        end
        total++;
        if (mon_err != 0) begin
            bad++; $display("FAIL tx_framing got=%0d bad frames want=0", mon_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_and_identity();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
